// File: rtl/count_sched_ctrl_pkg.sv
// Shared definitions for the counterMod scheduler: FSM state encoding,
// default timeout sizing and a small index helper.
package count_sched_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

    localparam int TIMEOUT_DEF = 64;
    localparam int TO_W_DEF    = 7;

    // Successor of a requester index in round-robin order.
    function automatic int wrap_inc(input int idx, input int num);
        return (idx + 1 >= num) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first active request at or after ptr
// (modulo NUM_REQ) wins. The owning controller registers the result.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   owner,
    output logic               valid
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        // NOTE: every output gets a default before the search loop so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        gnt   = '0;
        owner = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!valid && req[idx]) begin
                valid    = 1'b1;
                gnt[idx] = 1'b1;
                owner    = idx;
            end
        end
    end

endmodule

// File: rtl/count_sched_ctrl.sv
// Shares one counterMod between NUM_REQ requesters: round-robin grant, counter
// clear, run until op_done (or timeout), then a one-cycle done/err to the owner.
module count_sched_ctrl
    import count_sched_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TO_W    = TO_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] done,
    output logic               err,
    output logic               cnt_clr,
    output logic               cnt_en,
    input  logic               cnt_done,
    output logic               busy
);

    localparam int               IDX_W   = $clog2(NUM_REQ);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [TO_W-1:0]    to_cnt;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_owner;
    logic               arb_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .gnt   (arb_gnt),
        .owner (arb_owner),
        .valid (arb_valid)
    );

    // Outputs are set on the transition into the state that owns them, so every
    // output is a flop and nothing combinational reaches a port.
    always_ff @(posedge clock) begin
        // NOTE: all state here uses non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (reset) begin
            state   <= ST_IDLE;
            grant   <= '0;
            done    <= '0;
            err     <= 1'b0;
            cnt_clr <= 1'b0;
            cnt_en  <= 1'b0;
            busy    <= 1'b0;
            ptr     <= '0;
            owner   <= '0;
            to_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant   <= arb_gnt;
                        owner   <= arb_owner;
                        cnt_clr <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ST_CLEAR;
                    end
                end

                ST_CLEAR: begin
                    cnt_clr <= 1'b0;
                    cnt_en  <= 1'b1;
                    to_cnt  <= '0;
                    state   <= ST_RUN;
                end

                ST_RUN: begin
                    if (to_cnt != TO_LAST) begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                    // Completion outranks both the timeout and a dropped request.
                    if (cnt_done) begin
                        done   <= grant;
                        err    <= 1'b0;
                        cnt_en <= 1'b0;
                        state  <= ST_DONE;
                    end else if (to_cnt == TO_LAST) begin
                        done   <= grant;
                        err    <= 1'b1;
                        cnt_en <= 1'b0;
                        state  <= ST_DONE;
                    end else if (!req[owner]) begin
                        grant  <= '0;
                        cnt_en <= 1'b0;
                        state  <= ST_ABORT;
                    end
                end

                ST_DONE: begin
                    done  <= '0;
                    err   <= 1'b0;
                    grant <= '0;
                    busy  <= 1'b0;
                    ptr   <= IDX_W'(wrap_inc(int'(owner), NUM_REQ));
                    state <= ST_IDLE;
                end

                ST_ABORT: begin
                    busy  <= 1'b0;
                    ptr   <= IDX_W'(wrap_inc(int'(owner), NUM_REQ));
                    state <= ST_IDLE;
                end

                default: begin
                    grant   <= '0;
                    done    <= '0;
                    err     <= 1'b0;
                    cnt_clr <= 1'b0;
                    cnt_en  <= 1'b0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
